// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall vector layout,
// stall patterns, FSM encoding and the stall selection rule.
package pipe_stall_ctrl_pkg;

    localparam int unsigned InstAddrBusW = 32;
    localparam int unsigned StallW       = 6;

    // Stall vector bit positions, one per pipeline register.
    localparam int unsigned StallPc    = 0;
    localparam int unsigned StallIfId  = 1;
    localparam int unsigned StallIdEx  = 2;
    localparam int unsigned StallExMem = 3;
    localparam int unsigned StallMemWb = 4;
    localparam int unsigned StallWb    = 5;

    localparam logic [StallW-1:0] STALL_NONE   = 6'b000000;
    localparam logic [StallW-1:0] STALL_BUBBLE = 6'b000111;
    localparam logic [StallW-1:0] STALL_MEM    = 6'b011111;

    localparam logic [4:0] NopRegAddr = 5'd0;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StMemw  = 2'd1,
        StFlush = 2'd2
    } state_e;

    // The flush cycle wins over a memory wait, which wins over a hazard bubble.
    function automatic logic [StallW-1:0] stall_sel(state_e st, logic mem_busy, logic bbl_req);
        if (st == StFlush) begin
            return STALL_NONE;
        end else if (mem_busy) begin
            return STALL_MEM;
        end else if (bbl_req) begin
            return STALL_BUBBLE;
        end
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/control bundle between the core and the stall controller.
// master = core side (drives requests), slave = stall controller.
interface pipe_stall_ctrl_if
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);

    logic                    bbl_req;
    logic                    mem_busy;
    logic                    flush_req;
    logic [InstAddrBusW-1:0] flush_pc;
    logic [StallW-1:0]       stall;
    logic                    flush;
    logic                    pc_load;
    logic [InstAddrBusW-1:0] new_pc;
    logic [CNT_W-1:0]        bubble_cnt;
    logic [CNT_W-1:0]        memw_cnt;
    logic                    mem_timeout;

    modport master (
        output bbl_req, mem_busy, flush_req, flush_pc,
        input  stall, flush, pc_load, new_pc, bubble_cnt, memw_cnt, mem_timeout
    );

    modport slave (
        input  bbl_req, mem_busy, flush_req, flush_pc,
        output stall, flush, pc_load, new_pc, bubble_cnt, memw_cnt, mem_timeout
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Turns hazard bubbles, memory waits and redirect requests into per-stage stall enables
// and a one-cycle flush with PC load; also keeps stall statistics and a memory watchdog.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    pipe_stall_ctrl_if.slave bus_io
);

    localparam int unsigned     RunW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(MEM_TIMEOUT);

    state_e                  state_q;
    logic                    flush_q, pc_load_q;
    logic [InstAddrBusW-1:0] new_pc_q;
    logic                    pend_vld_q;
    logic [InstAddrBusW-1:0] pend_pc_q;
    logic [RunW-1:0]         run_d, run_q;
    logic                    timeout_d, timeout_q;
    logic                    in_flush;
    logic                    bubble_inc, memw_inc;

    assign in_flush = (state_q == StFlush);

    // A redirect is never issued while MEM is busy; it parks in the pending register instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            flush_q    <= 1'b0;
            pc_load_q  <= 1'b0;
            new_pc_q   <= '0;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            flush_q   <= 1'b0;
            pc_load_q <= 1'b0;
            if (bus_io.mem_busy) begin
                state_q <= StMemw;
                if (bus_io.flush_req) begin
                    pend_vld_q <= 1'b1;
                    pend_pc_q  <= bus_io.flush_pc;
                end
            end else if (bus_io.flush_req || pend_vld_q) begin
                state_q    <= StFlush;
                flush_q    <= 1'b1;
                pc_load_q  <= 1'b1;
                new_pc_q   <= bus_io.flush_req ? bus_io.flush_pc : pend_pc_q;
                pend_vld_q <= 1'b0;
            end else begin
                state_q <= StRun;
            end
        end
    end

    // Consecutive mem_busy run length; the timeout flag is sticky until reset.
    always_comb begin
        run_d     = run_q;
        timeout_d = timeout_q;
        if (!bus_io.mem_busy) begin
            run_d = '0;
        end else if (run_q != RunMax) begin
            run_d = run_q + 1'b1;
        end
        if (bus_io.mem_busy && (run_d == RunMax)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign bubble_inc = !in_flush && !bus_io.mem_busy && bus_io.bbl_req;
    assign memw_inc   = !in_flush && bus_io.mem_busy;

    sat_counter #(
        .Width (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (bubble_inc),
        .cnt_o (bus_io.bubble_cnt)
    );

    sat_counter #(
        .Width (CNT_W)
    ) u_memw_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (memw_inc),
        .cnt_o (bus_io.memw_cnt)
    );

    assign bus_io.stall       = stall_sel(state_q, bus_io.mem_busy, bus_io.bbl_req);
    assign bus_io.flush       = flush_q;
    assign bus_io.pc_load     = pc_load_q;
    assign bus_io.new_pc      = new_pc_q;
    assign bus_io.mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a behavioural model (two parameter sets).
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        bbl, mb, fr;
    logic [31:0] fpc;
    logic        chk_en;
    int          errors;
    int          checks;

    pipe_stall_ctrl_if #(.CNT_W(32)) a_if ();
    pipe_stall_ctrl_if #(.CNT_W(3))  b_if ();

    assign a_if.bbl_req   = bbl;
    assign a_if.mem_busy  = mb;
    assign a_if.flush_req = fr;
    assign a_if.flush_pc  = fpc;
    assign b_if.bbl_req   = bbl;
    assign b_if.mem_busy  = mb;
    assign b_if.flush_req = fr;
    assign b_if.flush_pc  = fpc;

    pipe_stall_ctrl #(
        .CNT_W       (32),
        .MEM_TIMEOUT (255)
    ) dut_a (
        .clk    (clk),
        .rst    (rst),
        .bus_io (a_if)
    );

    pipe_stall_ctrl #(
        .CNT_W       (3),
        .MEM_TIMEOUT (4)
    ) dut_b (
        .clk    (clk),
        .rst    (rst),
        .bus_io (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: index 0 = dut_a, index 1 = dut_b.
    longint unsigned cap [2] = '{64'hFFFF_FFFF, 64'd7};
    int              tmo [2] = '{255, 4};
    longint unsigned m_bub [2];
    longint unsigned m_memw [2];
    int              m_run [2];
    bit              m_to [2];
    bit              m_in_flush;
    bit              m_pend;
    logic [31:0]     m_pend_pc;
    logic [31:0]     m_new_pc;

    task automatic model_step();
        if (rst) begin
            m_in_flush = 0;
            m_pend     = 0;
            m_pend_pc  = '0;
            m_new_pc   = '0;
            for (int k = 0; k < 2; k++) begin
                m_bub[k] = 0; m_memw[k] = 0; m_run[k] = 0; m_to[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_in_flush) begin
                    if (mb) begin
                        if (m_memw[k] < cap[k]) m_memw[k]++;
                    end else if (bbl) begin
                        if (m_bub[k] < cap[k]) m_bub[k]++;
                    end
                end
                if (mb) begin
                    if (m_run[k] < tmo[k]) m_run[k]++;
                    if (m_run[k] >= tmo[k]) m_to[k] = 1;
                end else begin
                    m_run[k] = 0;
                end
            end
            if (!mb && (fr || m_pend)) begin
                m_new_pc   = fr ? fpc : m_pend_pc;
                m_pend     = 0;
                m_in_flush = 1;
            end else begin
                m_in_flush = 0;
                if (mb && fr) begin
                    m_pend    = 1;
                    m_pend_pc = fpc;
                end
            end
        end
    endtask

    function automatic logic [5:0] exp_stall();
        if (m_in_flush) return 6'b000000;
        if (mb)         return 6'b011111;
        if (bbl)        return 6'b000111;
        return 6'b000000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst) begin
                chk("stall_a", 64'(a_if.stall), 64'(exp_stall()));
                chk("stall_b", 64'(b_if.stall), 64'(exp_stall()));
            end
            chk("flush_a",   64'(a_if.flush),       64'(m_in_flush));
            chk("pc_load_a", 64'(a_if.pc_load),     64'(m_in_flush));
            chk("new_pc_a",  64'(a_if.new_pc),      64'(m_new_pc));
            chk("bub_a",     64'(a_if.bubble_cnt),  m_bub[0]);
            chk("memw_a",    64'(a_if.memw_cnt),    m_memw[0]);
            chk("tmo_a",     64'(a_if.mem_timeout), 64'(m_to[0]));
            chk("flush_b",   64'(b_if.flush),       64'(m_in_flush));
            chk("new_pc_b",  64'(b_if.new_pc),      64'(m_new_pc));
            chk("bub_b",     64'(b_if.bubble_cnt),  m_bub[1]);
            chk("memw_b",    64'(b_if.memw_cnt),    m_memw[1]);
            chk("tmo_b",     64'(b_if.mem_timeout), 64'(m_to[1]));
        end
    end

    // One clock: model absorbs the inputs sampled at this edge, then new inputs are driven.
    task automatic cyc(input logic r, input logic b, input logic m, input logic f,
                       input logic [31:0] pc);
        @(posedge clk);
        model_step();
        #1;
        rst = r; bbl = b; mb = m; fr = f; fpc = pc;
        @(negedge clk);
    endtask

    int mb_left;

    initial begin
        errors = 0; checks = 0; chk_en = 0; mb_left = 0;
        rst = 1'b1; bbl = 1'b1; mb = 1'b1; fr = 1'b1; fpc = 32'hFFFF_FFFF;

        // Reset held 3 cycles with every input high.
        cyc(1, 1, 1, 1, 32'hFFFF_FFFF);
        chk_en = 1;
        cyc(1, 1, 1, 1, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 0, 32'h0);
        chk("rst_stall", 64'(a_if.stall), 64'h0);
        chk("rst_flush", 64'(a_if.flush), 64'h0);
        chk("rst_bub",   64'(a_if.bubble_cnt), 64'h0);
        chk("rst_memw",  64'(a_if.memw_cnt), 64'h0);

        // Hazard bubble for two cycles.
        cyc(0, 1, 0, 0, 32'h0);
        chk("haz_stall1", 64'(a_if.stall), 64'b000111);
        cyc(0, 1, 0, 0, 32'h0);
        chk("haz_stall2", 64'(a_if.stall), 64'b000111);
        cyc(0, 0, 0, 0, 32'h0);
        chk("haz_stall3", 64'(a_if.stall), 64'h0);
        chk("haz_bub",    64'(a_if.bubble_cnt), 64'd2);
        chk("haz_flush",  64'(a_if.flush), 64'h0);

        // Memory wait dominates a concurrent hazard.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, 0, 32'h0);
            chk("memh_stall", 64'(a_if.stall), 64'b011111);
        end
        cyc(0, 1, 0, 0, 32'h0);
        chk("memh_after", 64'(a_if.stall), 64'b000111);
        chk("memh_memw",  64'(a_if.memw_cnt), 64'd4);
        chk("memh_bub",   64'(a_if.bubble_cnt), 64'd2);
        chk("memh_tmo_b", 64'(b_if.mem_timeout), 64'd1);
        chk("memh_tmo_a", 64'(a_if.mem_timeout), 64'd0);

        // Flush requested during a memory access is deferred until it completes.
        cyc(0, 0, 1, 1, 32'h0000_0100);
        cyc(0, 0, 1, 0, 32'h0);
        cyc(0, 0, 1, 0, 32'h0);
        chk("dfl_busy_flush", 64'(a_if.flush), 64'h0);
        cyc(0, 0, 0, 0, 32'h0);
        chk("dfl_drop_flush", 64'(a_if.flush), 64'h0);
        cyc(0, 0, 0, 0, 32'h0);
        chk("dfl_flush",  64'(a_if.flush), 64'h1);
        chk("dfl_pcld",   64'(a_if.pc_load), 64'h1);
        chk("dfl_newpc",  64'(a_if.new_pc), 64'h100);
        chk("dfl_stall",  64'(a_if.stall), 64'h0);
        cyc(0, 0, 0, 0, 32'h0);
        chk("dfl_end",    64'(a_if.flush), 64'h0);

        // Back-to-back redirects; bubbles during flush cycles are not counted.
        cyc(0, 0, 0, 1, 32'h0000_0200);
        cyc(0, 1, 0, 1, 32'h0000_0300);
        chk("b2b_flush1", 64'(a_if.flush), 64'h1);
        chk("b2b_pc1",    64'(a_if.new_pc), 64'h200);
        chk("b2b_stall1", 64'(a_if.stall), 64'h0);
        cyc(0, 1, 0, 0, 32'h0);
        chk("b2b_flush2", 64'(a_if.flush), 64'h1);
        chk("b2b_pc2",    64'(a_if.new_pc), 64'h300);
        cyc(0, 0, 0, 0, 32'h0);
        chk("b2b_end",    64'(a_if.flush), 64'h0);
        chk("b2b_bub_a",  64'(a_if.bubble_cnt), 64'd3);
        chk("b2b_bub_b",  64'(b_if.bubble_cnt), 64'd3);

        // Watchdog and saturation on the narrow instance.
        cyc(1, 0, 0, 0, 32'h0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 1, 0, 32'h0);
            chk("wd_memw_b", 64'(b_if.memw_cnt), 64'((i - 1) < 7 ? (i - 1) : 7));
            chk("wd_tmo_b",  64'(b_if.mem_timeout), 64'((i - 1) >= 4));
        end
        cyc(0, 0, 0, 0, 32'h0);
        chk("wd_memw_sat", 64'(b_if.memw_cnt), 64'd7);
        chk("wd_memw_a",   64'(a_if.memw_cnt), 64'd10);
        cyc(0, 0, 0, 0, 32'h0);
        chk("wd_sticky",   64'(b_if.mem_timeout), 64'd1);
        chk("wd_tmo_a",    64'(a_if.mem_timeout), 64'd0);

        // Random traffic, including one long wait to trip the wide watchdog.
        for (int n = 0; n < 2000; n++) begin
            logic r, b, f;
            r = ($urandom_range(0, 99) == 0);
            b = $urandom_range(0, 1);
            f = ($urandom_range(0, 9) == 0);
            if (n == 500) mb_left = 260;
            if (mb_left == 0 && $urandom_range(0, 5) == 0) mb_left = $urandom_range(1, 6);
            cyc(r, b, mb_left > 0, f, $urandom);
            if (mb_left > 0) mb_left--;
        end
        cyc(0, 0, 0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
